// File: rtl/flex_timer_pkg.sv
// rtl/flex_timer_pkg.sv - shared types and default parameters for flex_down_timer
package flex_timer_pkg;

    localparam int unsigned DEF_NUM_CNT_BITS = 4;
    localparam int unsigned DEF_PRESCALE_DIV = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - enabled-cycle divider for flex_down_timer (used with FLEX_TIMER_PRESCALE_EN)
module timer_prescaler
    import flex_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = DEF_PRESCALE_DIV
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE_DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] cnt;

    // tick marks the enabled cycle on which the divider completes a full period
    assign tick = en && (cnt == LAST);

    // count enabled cycles, wrap after the last one; hold while disabled
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/flex_down_timer.sv
// rtl/flex_down_timer.sv - loadable one-shot/periodic down timer; optional prescaler via FLEX_TIMER_PRESCALE_EN
module flex_down_timer
    import flex_timer_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS,
    parameter int unsigned PRESCALE_DIV = DEF_PRESCALE_DIV
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clr,
    input  logic                    start,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    periodic,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    expire
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    state_t                  state;
    logic [NUM_CNT_BITS-1:0] reload_q;
    logic                    periodic_q;
    logic                    dec_tick;

`ifdef FLEX_TIMER_PRESCALE_EN
    logic pre_en;
    logic pre_clr;

    // the divider only advances on enabled RUN cycles and restarts with every clr/start
    assign pre_en  = count_enable && (state == RUN);
    assign pre_clr = clr || start;

    timer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .n_rst(n_rst),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (dec_tick)
    );
`else
    logic unused_prescale;

    // without the divider every enabled cycle is a decrement opportunity
    assign dec_tick        = count_enable;
    assign unused_prescale = ^PRESCALE_DIV;
`endif

    assign busy = (state == RUN);

    // main FSM: clr > start > decrement/terminal > hold
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            count_out  <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            expire     <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            count_out <= '0;
            expire    <= 1'b0;
        end else if (start) begin
            reload_q   <= load_val;
            periodic_q <= periodic;
            count_out  <= load_val;
            if (load_val == '0) begin
                // zero load expires immediately and never enters RUN
                state  <= IDLE;
                expire <= 1'b1;
            end else begin
                state  <= RUN;
                expire <= 1'b0;
            end
        end else if ((state == RUN) && dec_tick && (count_out == ONE)) begin
            expire <= 1'b1;
            if (periodic_q) begin
                count_out <= reload_q;
            end else begin
                count_out <= '0;
                state     <= IDLE;
            end
        end else if ((state == RUN) && dec_tick && (count_out > ONE)) begin
            count_out <= count_out - ONE;
            expire    <= 1'b0;
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flex_down_timer.sv
// tb/tb_flex_down_timer.sv - scoreboard bench for flex_down_timer
module tb_flex_down_timer;

    typedef struct {
        logic [3:0] cnt;
        logic       busy;
        logic       exp;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       periodic = 1'b0;
    logic       count_enable = 1'b0;
    logic [3:0] count_out;
    logic       busy;
    logic       expire;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];
    exp_t mon_e;

    flex_down_timer #(
        .NUM_CNT_BITS(4),
        .PRESCALE_DIV(4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clr         (clr),
        .start       (start),
        .load_val    (load_val),
        .periodic    (periodic),
        .count_enable(count_enable),
        .count_out   (count_out),
        .busy        (busy),
        .expire      (expire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // one stimulus vector applied for one clock, expected outputs queued
    task automatic step(input logic c, input logic s, input int lv, input logic p,
                        input logic e, input int ec, input logic eb, input logic ee,
                        input string nm);
        exp_t x;
        @(negedge clk);
        clr          = c;
        start        = s;
        load_val     = lv[3:0];
        periodic     = p;
        count_enable = e;
        x.cnt  = ec[3:0];
        x.busy = eb;
        x.exp  = ee;
        x.nm   = nm;
        sb.push_back(x);
    endtask

    // monitor: the DUT presents new outputs after every edge; compare against the queue
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.nm, ".count"}, int'(count_out), int'(mon_e.cnt));
            chk({mon_e.nm, ".busy"}, int'(busy), int'(mon_e.busy));
            chk({mon_e.nm, ".expire"}, int'(expire), int'(mon_e.exp));
        end
    end

    initial begin
        int c;
        #3;
        chk("reset.count", int'(count_out), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.expire", int'(expire), 0);
        @(negedge clk);
        n_rst = 1'b1;

`ifdef FLEX_TIMER_PRESCALE_EN
        step(0, 1, 2, 0, 1, 2, 1, 0, "pre_start");
        for (int i = 1; i <= 8; i++) begin
            if (i < 4)       step(0, 0, 0, 0, 1, 2, 1, 0, "pre_hold2");
            else if (i == 4) step(0, 0, 0, 0, 1, 1, 1, 0, "pre_dec");
            else if (i < 8)  step(0, 0, 0, 0, 1, 1, 1, 0, "pre_hold1");
            else             step(0, 0, 0, 0, 1, 0, 0, 1, "pre_expire");
        end
        step(0, 1, 2, 0, 1, 2, 1, 0, "pre_restart");
        step(0, 0, 0, 0, 1, 2, 1, 0, "pre_mid1");
        step(0, 0, 0, 0, 1, 2, 1, 0, "pre_mid2");
        step(1, 0, 0, 0, 1, 0, 0, 0, "pre_clr");
        step(0, 1, 2, 0, 1, 2, 1, 0, "pre_start2");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 2, 1, 0, "pre_fresh");
        step(0, 0, 0, 0, 1, 1, 1, 0, "pre_fresh_dec");
`else
        // one-shot load 5
        step(0, 1, 5, 0, 1, 5, 1, 0, "os_start");
        for (int v = 4; v >= 1; v--) step(0, 0, 0, 0, 1, v, 1, 0, "os_dec");
        step(0, 0, 0, 0, 1, 0, 0, 1, "os_expire");
        step(0, 0, 0, 0, 1, 0, 0, 0, "os_idle");

        // periodic load 3, ten enabled cycles
        step(0, 1, 3, 1, 1, 3, 1, 0, "per_start");
        c = 3;
        for (int i = 0; i < 10; i++) begin
            if (c == 1) begin
                c = 3;
                step(0, 0, 0, 0, 1, c, 1, 1, "per_reload");
            end else begin
                c = c - 1;
                step(0, 0, 0, 0, 1, c, 1, 0, "per_dec");
            end
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, "per_clr");

        // gated enable, load 4, enable 1,0,0,1,1,1
        step(0, 1, 4, 0, 0, 4, 1, 0, "gate_start");
        step(0, 0, 0, 0, 1, 3, 1, 0, "gate_en1");
        step(0, 0, 0, 0, 0, 3, 1, 0, "gate_hold");
        step(0, 0, 0, 0, 0, 3, 1, 0, "gate_hold");
        step(0, 0, 0, 0, 1, 2, 1, 0, "gate_en2");
        step(0, 0, 0, 0, 1, 1, 1, 0, "gate_en3");
        step(0, 0, 0, 0, 1, 0, 0, 1, "gate_expire");

        // zero load expires immediately
        step(0, 1, 0, 0, 1, 0, 0, 1, "zero_start");
        step(0, 0, 0, 0, 1, 0, 0, 0, "zero_after");

        // max load 15 takes 15 enabled cycles
        step(0, 1, 15, 0, 1, 15, 1, 0, "max_start");
        for (int v = 14; v >= 1; v--) step(0, 0, 0, 0, 1, v, 1, 0, "max_dec");
        step(0, 0, 0, 0, 1, 0, 0, 1, "max_expire");

        // periodic load 1 expires every enabled cycle
        step(0, 1, 1, 1, 1, 1, 1, 0, "p1_start");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1, 1, 1, "p1_expire");
        step(1, 0, 0, 0, 1, 0, 0, 0, "p1_clr");

        // clr wins over start
        step(0, 1, 6, 0, 0, 6, 1, 0, "cs_run");
        step(1, 1, 9, 0, 1, 0, 0, 0, "cs_both");
        step(0, 0, 0, 0, 1, 0, 0, 0, "cs_idle");

        // restart mid-count
        step(0, 1, 5, 0, 1, 5, 1, 0, "rs_start");
        step(0, 0, 0, 0, 1, 4, 1, 0, "rs_dec");
        step(0, 0, 0, 0, 1, 3, 1, 0, "rs_dec");
        step(0, 0, 0, 0, 1, 2, 1, 0, "rs_dec");
        step(0, 1, 7, 0, 1, 7, 1, 0, "rs_restart");
        step(0, 0, 0, 0, 0, 7, 1, 0, "rs_hold");

        // asynchronous reset mid-run
        step(0, 1, 9, 0, 1, 9, 1, 0, "ar_start");
        step(0, 0, 0, 0, 1, 8, 1, 0, "ar_dec");
        @(negedge clk);
        start = 1'b0;
        count_enable = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_rst.count", int'(count_out), 0);
        chk("async_rst.busy", int'(busy), 0);
        chk("async_rst.expire", int'(expire), 0);
        @(negedge clk);
        n_rst = 1'b1;
        step(0, 0, 0, 0, 1, 0, 0, 0, "ar_after");
`endif

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
